truth_table_sweeper: RTL and testbench

- Parametrised, self-checking exhaustive stimulus engine for combinational lab blocks with N_IN inputs and N_OUT outputs.
- Drives every input combination 0..2^N_IN-1 in ascending order onto the DUT.
- After a programmable settle time, samples the DUT outputs and compacts them into a MISR signature.
- Compares the final signature against an expected value and reports pass/fail, replacing hand-written per-vector benches.

---
 rtl/truth_table_sweeper.sv | 125 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives vectors 0..2^N_IN-1, folds DUT outputs into a MISR, flags pass/fail.
// Each vector takes SETTLE+2 cycles and done follows the last SAMPLE by one cycle; there is no backpressure and abort ends a sweep.
module truth_table_sweeper #(
  parameter int              N_IN   = 3,
  parameter int              N_OUT  = 6,
  parameter int              SETTLE = 1,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] expected_sig,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [N_IN-1:0] LAST_VEC  = '1;
  localparam logic [7:0]      WAIT_INIT = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  state_t           state_q;
  logic [N_IN-1:0]  vec_q;
  logic [7:0]       wait_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] exp_q;

  // Next MISR value if the current dut_out were folded in this cycle.
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(dut_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= SEED;
      exp_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // busy_q tracks APPLY/WAIT/SAMPLE exactly, so abort outranks the SAMPLE->FINISH step.
      if (abort && busy_q) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              exp_q   <= expected_sig;
              sig_q   <= SEED;
              vec_q   <= '0;
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_APPLY;
            end
          end
          S_APPLY: begin
            if (SETTLE == 0) begin
              state_q <= S_SAMPLE;
            end else begin
              wait_q  <= WAIT_INIT;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (wait_q == 8'd0) begin
              state_q <= S_SAMPLE;
            end else begin
              wait_q <= wait_q - 8'd1;
            end
          end
          S_SAMPLE: begin
            sig_q <= sig_d;
            if (vec_q == LAST_VEC) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == exp_q);
              state_q <= S_FINISH;
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= S_APPLY;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign dut_in    = vec_q;
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: scoreboard of expected vectors/signatures, plus a 1-input zero-settle instance.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst, start, abort, start1;
  logic [15:0] expected_sig, exp1;
  logic [2:0]  dut_in, vec_idx;
  logic [5:0]  dut_out;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [0:0]  dut_in1, vec_idx1, dut_out1;
  logic        busy1, done1, pass1;
  logic [15:0] sig1;
  logic [1:0]  mode;

  int n_chk = 0;
  int n_err = 0;
  logic [2:0]  vq[$];
  logic [15:0] sq[$];

  always #5 clk = ~clk;

  assign dut_out  = (mode == 2'd0) ? {3'b000, dut_in} : (mode == 2'd1) ? 6'h00 : 6'h3F;
  assign dut_out1 = dut_in1;

  truth_table_sweeper #(
    .N_IN(3), .N_OUT(6), .SETTLE(1), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_sig(expected_sig),
    .dut_in(dut_in), .dut_out(dut_out), .vec_idx(vec_idx), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  truth_table_sweeper #(
    .N_IN(1), .N_OUT(1), .SETTLE(0), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .expected_sig(exp1),
    .dut_in(dut_in1), .dut_out(dut_out1), .vec_idx(vec_idx1), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [5:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'b0, r};
  endfunction

  // Called just after a negedge; runs one full 8-vector sweep (3 cycles per vector).
  task automatic sweep(input logic [15:0] exp, input logic [1:0] m, input bit with_abort);
    logic [15:0] s;
    logic [2:0]  v;
    s = 16'h0000;
    mode = m;
    expected_sig = exp;
    for (int k = 0; k < 8; k++) begin
      s = misr(s, (m == 2'd0) ? 6'(k) : 6'h00);
      vq.push_back(3'(k));
      sq.push_back(s);
    end
    start = 1'b1;
    abort = with_abort;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c <= 24 && (c - 1) % 3 == 0) begin
        v = vq.pop_front();
        check("vec_dut_in", 32'(dut_in), 32'(v));
        check("vec_idx", 32'(vec_idx), 32'(v));
        check("vec_busy", 32'(busy), 32'd1);
      end
      if (c >= 4 && (c - 1) % 3 == 0) check("sig_step", 32'(signature), 32'(sq.pop_front()));
      if (c == 24) check("done_early", 32'(done), 32'd0);
    end
    check("done", 32'(done), 32'd1);
    check("busy_fin", 32'(busy), 32'd0);
    check("pass", 32'(pass), 32'(s == exp));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("pass_hold", 32'(pass), 32'(s == exp));
    check("sig_hold", 32'(signature), 32'(s));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    expected_sig = 16'h0000; exp1 = 16'h0000; mode = 2'd2;
    repeat (2) @(negedge clk);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    check("rst_vec_idx", 32'(vec_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(signature), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    sweep(16'h000F, 2'd0, 1'b0);
    sweep(16'h000E, 2'd0, 1'b0);
    sweep(16'h0000, 2'd1, 1'b1);

    // Start mid-sweep is ignored; abort lands on vector 4's SAMPLE cycle.
    mode = 2'd0;
    expected_sig = 16'h000F;
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) check("start_ignored", 32'(vec_idx), 32'd1);
      if (c == 15) begin
        check("abort_vec", 32'(vec_idx), 32'd4);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("abort_done", 32'(done), 32'd0);
      check("abort_sig", 32'(signature), 32'h0003);
      @(negedge clk);
    end

    // Reset during vector 5, then a clean sweep.
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 16) begin
        check("rst_mid_vec", 32'(vec_idx), 32'd5);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    check("mrst_dut_in", 32'(dut_in), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_pass", 32'(pass), 32'd0);
    check("mrst_sig", 32'(signature), 32'd0);
    sweep(16'h000F, 2'd0, 1'b0);

    // One input, zero settle: 2 vectors of 2 cycles, done in cycle 5.
    exp1 = 16'h0001;
    start1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (c == 1) check("n1_vec0", 32'(dut_in1), 32'd0);
      if (c == 3) begin
        check("n1_vec1", 32'(dut_in1), 32'd1);
        check("n1_sig0", 32'(sig1), 32'd0);
      end
      if (c == 4) check("n1_done_early", 32'(done1), 32'd0);
      if (c == 5) begin
        check("n1_done", 32'(done1), 32'd1);
        check("n1_sig", 32'(sig1), 32'd1);
        check("n1_pass", 32'(pass1), 32'd1);
      end
    end
    @(negedge clk);
    check("n1_done_pulse", 32'(done1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
